// File: rtl/st_adapter_pkg.sv
// Shared encodings and helpers for the Avalon-ST channel filter adapter.
package st_adapter_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_PASS = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  // Width of the {data, channel, sop, eop} bundle carried by the skid buffer.
  function automatic int payload_w(input int data_w, input int out_ch_w);
    return data_w + out_ch_w + 2;
  endfunction

endpackage

// File: rtl/st_skid_buffer.sv
// Two-entry valid/ready skid buffer; in_ready is a register so the
// downstream ready never reaches the upstream ready combinationally.
module st_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] out_data_o
);

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_ready_q, in_ready_d;
  logic             in_fire_s;
  logic             out_free_s;

  // Next-state of the output entry, the skid entry and the registered ready.
  always_comb begin
    in_fire_s    = in_valid_i & in_ready_q;
    out_free_s   = ~out_valid_q | out_ready_i;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free_s) begin
      if (skid_valid_q) begin
        // in_ready is low whenever the skid entry is occupied, so no input here.
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire_s;
        out_data_d  = in_fire_s ? in_data_i : out_data_q;
      end
    end else begin
      if (in_fire_s) begin
        skid_valid_d = 1'b1;
        skid_data_d  = in_data_i;
      end else begin
        skid_valid_d = skid_valid_q;
      end
    end
    in_ready_d = ~skid_valid_d;
  end

  // Entry and ready registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      in_ready_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_data_o  = out_data_q;

endmodule

// File: rtl/st_channel_filter_adapter.sv
// Avalon-ST channel adapter: drops whole packets whose SOP channel exceeds
// MAX_CHANNEL and forwards the rest through a skid buffer.
module st_channel_filter_adapter
  import st_adapter_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int IN_CHANNEL_W  = 8,
  parameter int OUT_CHANNEL_W = 1,
  parameter int MAX_CHANNEL   = 0,
  parameter int DROP_CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     in_ready,
  input  logic                     in_valid,
  input  logic [DATA_W-1:0]        in_data,
  input  logic [IN_CHANNEL_W-1:0]  in_channel,
  input  logic                     in_startofpacket,
  input  logic                     in_endofpacket,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [OUT_CHANNEL_W-1:0] out_channel,
  output logic                     out_startofpacket,
  output logic                     out_endofpacket,
  output logic [DROP_CNT_W-1:0]    drop_count,
  output logic                     orphan_err
);

  localparam int                      PW     = payload_w(DATA_W, OUT_CHANNEL_W);
  localparam logic [IN_CHANNEL_W-1:0] MAX_CH = IN_CHANNEL_W'(MAX_CHANNEL);
  localparam logic [DROP_CNT_W-1:0]   CNT_MAX = {DROP_CNT_W{1'b1}};

  logic [1:0]               state_q, state_d;
  logic [OUT_CHANNEL_W-1:0] chan_q, chan_d;
  logic [DROP_CNT_W-1:0]    drop_q, drop_d;
  logic                     orphan_q, orphan_d;
  logic                     accept_s;
  logic                     fwd_s;
  logic [OUT_CHANNEL_W-1:0] fwd_chan_s;
  logic [PW-1:0]            in_payload_s;
  logic [PW-1:0]            out_payload_s;

  // Packet filter: decides forward/discard per accepted beat.
  always_comb begin
    accept_s   = in_valid & in_ready;
    state_d    = state_q;
    chan_d     = chan_q;
    drop_d     = drop_q;
    orphan_d   = orphan_q;
    fwd_s      = 1'b0;
    fwd_chan_s = chan_q;
    if (accept_s) begin
      if (in_startofpacket) begin
        // Every SOP re-evaluates the channel, even inside an unterminated packet.
        if (in_channel <= MAX_CH) begin
          fwd_s      = 1'b1;
          chan_d     = in_channel[OUT_CHANNEL_W-1:0];
          fwd_chan_s = in_channel[OUT_CHANNEL_W-1:0];
          state_d    = in_endofpacket ? ST_IDLE : ST_PASS;
        end else begin
          if (drop_q != CNT_MAX) begin
            drop_d = drop_q + DROP_CNT_W'(1);
          end else begin
            drop_d = drop_q;
          end
          state_d = in_endofpacket ? ST_IDLE : ST_DROP;
        end
      end else begin
        case (state_q)
          ST_PASS: begin
            fwd_s   = 1'b1;
            state_d = in_endofpacket ? ST_IDLE : ST_PASS;
          end
          ST_DROP: begin
            state_d = in_endofpacket ? ST_IDLE : ST_DROP;
          end
          default: begin
            orphan_d = 1'b1;
            state_d  = ST_IDLE;
          end
        endcase
      end
    end else begin
      state_d = state_q;
    end
  end

  // Filter state, channel latch and status counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      chan_q   <= '0;
      drop_q   <= '0;
      orphan_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      chan_q   <= chan_d;
      drop_q   <= drop_d;
      orphan_q <= orphan_d;
    end
  end

  assign in_payload_s = {in_data, fwd_chan_s, in_startofpacket, in_endofpacket};

  st_skid_buffer #(
    .WIDTH (PW)
  ) u_skid (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (fwd_s),
    .in_ready_o  (in_ready),
    .in_data_i   (in_payload_s),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
    .out_data_o  (out_payload_s)
  );

  assign {out_data, out_channel, out_startofpacket, out_endofpacket} = out_payload_s;
  assign drop_count = drop_q;
  assign orphan_err = orphan_q;

endmodule

// File: tb/tb_st_channel_filter_adapter.sv
// Self-checking bench for st_channel_filter_adapter: vector table plus
// hand-written backpressure, saturation and reset sequences.
module tb_st_channel_filter_adapter;

  logic       clk;
  logic       reset;
  logic       in_ready;
  logic       in_valid;
  logic [7:0] in_data;
  logic [7:0] in_channel;
  logic       in_startofpacket;
  logic       in_endofpacket;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic [0:0] out_channel;
  logic       out_startofpacket;
  logic       out_endofpacket;
  logic [1:0] drop_count;
  logic       orphan_err;

  st_channel_filter_adapter #(
    .DATA_W        (8),
    .IN_CHANNEL_W  (8),
    .OUT_CHANNEL_W (1),
    .MAX_CHANNEL   (0),
    .DROP_CNT_W    (2)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_ready          (in_ready),
    .in_valid          (in_valid),
    .in_data           (in_data),
    .in_channel        (in_channel),
    .in_startofpacket  (in_startofpacket),
    .in_endofpacket    (in_endofpacket),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_data          (out_data),
    .out_channel       (out_channel),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .drop_count        (drop_count),
    .orphan_err        (orphan_err)
  );

  typedef struct {
    logic       sop;
    logic       eop;
    logic [7:0] ch;
    logic [7:0] data;
    logic       fwd;
    logic [1:0] exp_drop;
    logic       exp_orph;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       ch;
    logic       sop;
    logic       eop;
    logic       chk;
    int         cyc;
  } sb_t;

  vec_t vecs [17];
  sb_t  sb [$];
  sb_t  e;
  int   tests = 0;
  int   fails = 0;
  int   cyc = 0;
  int   acc_cnt = 0;
  logic lat_mode;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset) acc_cnt <= 0;
    else if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Output monitor: every transfer must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_out: got data 0x%0h expected no output", out_data);
      end else begin
        e = sb.pop_front();
        chk("out_beat", {out_data, out_channel, out_startofpacket, out_endofpacket},
            {e.data, e.ch, e.sop, e.eop});
        if (e.chk) chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input vec_t v);
    bit got;
    sb_t s;
    got = 1'b0;
    in_valid         = 1'b1;
    in_data          = v.data;
    in_channel       = v.ch;
    in_startofpacket = v.sop;
    in_endofpacket   = v.eop;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (in_ready) begin
        if (v.fwd) begin
          s.data = v.data; s.ch = 1'b0; s.sop = v.sop; s.eop = v.eop;
          s.chk = lat_mode; s.cyc = cyc + 1;
          sb.push_back(s);
        end
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      tests++;
      fails++;
      $display("FAIL send_timeout: got in_ready 0 expected 1 within 200 cycles");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int k = 0; k < 50 && sb.size() != 0; k++) @(negedge clk);
    chk("sb_drained", sb.size(), 0);
  endtask

  function automatic vec_t mk(input logic sop, input logic eop, input logic [7:0] ch,
                              input logic [7:0] data, input logic fwd,
                              input logic [1:0] dc, input logic orph);
    vec_t v;
    v.sop = sop; v.eop = eop; v.ch = ch; v.data = data; v.fwd = fwd;
    v.exp_drop = dc; v.exp_orph = orph;
    return v;
  endfunction

  initial begin
    int base, a0, exp_drop;
    vec_t v;
    // Pass-through, ch 0
    vecs[0]  = mk(1'b1, 1'b0, 8'd0, 8'h11, 1'b1, 2'd0, 1'b0);
    vecs[1]  = mk(1'b0, 1'b0, 8'd0, 8'h12, 1'b1, 2'd0, 1'b0);
    vecs[2]  = mk(1'b0, 1'b0, 8'd0, 8'h13, 1'b1, 2'd0, 1'b0);
    vecs[3]  = mk(1'b0, 1'b1, 8'd0, 8'h14, 1'b1, 2'd0, 1'b0);
    // Dropped packet on ch 5, then single-beat packet on ch 0
    vecs[4]  = mk(1'b1, 1'b0, 8'd5, 8'h20, 1'b0, 2'd1, 1'b0);
    vecs[5]  = mk(1'b0, 1'b0, 8'd5, 8'h21, 1'b0, 2'd1, 1'b0);
    vecs[6]  = mk(1'b0, 1'b1, 8'd5, 8'h22, 1'b0, 2'd1, 1'b0);
    vecs[7]  = mk(1'b1, 1'b1, 8'd0, 8'hA5, 1'b1, 2'd1, 1'b0);
    // Channel changes mid-packet
    vecs[8]  = mk(1'b1, 1'b0, 8'd0, 8'h30, 1'b1, 2'd1, 1'b0);
    vecs[9]  = mk(1'b0, 1'b0, 8'd7, 8'h31, 1'b1, 2'd1, 1'b0);
    vecs[10] = mk(1'b0, 1'b1, 8'd7, 8'h32, 1'b1, 2'd1, 1'b0);
    // Orphan beat in IDLE
    vecs[11] = mk(1'b0, 1'b1, 8'd0, 8'h40, 1'b0, 2'd1, 1'b1);
    // Missing EOP: SOP on ch 3 inside a passing packet
    vecs[12] = mk(1'b1, 1'b0, 8'd0, 8'h50, 1'b1, 2'd1, 1'b1);
    vecs[13] = mk(1'b0, 1'b0, 8'd0, 8'h51, 1'b1, 2'd1, 1'b1);
    vecs[14] = mk(1'b1, 1'b0, 8'd3, 8'h52, 1'b0, 2'd2, 1'b1);
    vecs[15] = mk(1'b0, 1'b0, 8'd3, 8'h53, 1'b0, 2'd2, 1'b1);
    vecs[16] = mk(1'b0, 1'b1, 8'd3, 8'h54, 1'b0, 2'd2, 1'b1);

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_channel = 8'h00;
    in_startofpacket = 1'b0; in_endofpacket = 1'b0; out_ready = 1'b1; lat_mode = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_fields", {out_data, out_channel, out_startofpacket, out_endofpacket}, 0);
    chk("rst_drop_count", drop_count, 0);
    chk("rst_orphan", orphan_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("in_ready_after_rst", in_ready, 1);
    @(posedge clk); #1;

    for (int i = 0; i < 17; i++) begin
      send(vecs[i]);
      chk($sformatf("drop_count_v%0d", i), drop_count, vecs[i].exp_drop);
      chk($sformatf("orphan_v%0d", i), orphan_err, vecs[i].exp_orph);
      chk($sformatf("in_ready_v%0d", i), in_ready, 1);
    end
    drain();

    // Backpressure: out_ready low for 3 cycles while beat 3 is on the output
    lat_mode = 1'b0;
    base = acc_cnt;
    a0 = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          v = mk(i == 0, i == 7, 8'd0, 8'h70 + 8'(i), 1'b1, 2'd2, 1'b1);
          send(v);
        end
      end
      begin
        for (int k = 0; k < 100 && acc_cnt != base + 2; k++) @(negedge clk);
        @(posedge clk); #1;
        out_ready = 1'b0;
        a0 = acc_cnt;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          chk($sformatf("bp_in_ready_c%0d", k), in_ready, 0);
        end
        chk("bp_extra_accepts", acc_cnt - a0, 1);
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_total_accepts", acc_cnt - base, 8);

    // Drop-counter saturation
    lat_mode = 1'b1;
    exp_drop = 2;
    for (int i = 0; i < 5; i++) begin
      send(mk(1'b1, 1'b1, 8'd9, 8'h90 + 8'(i), 1'b0, 2'd0, 1'b1));
      exp_drop = (exp_drop == 3) ? 3 : exp_drop + 1;
      chk($sformatf("sat_drop_p%0d", i), drop_count, exp_drop);
    end
    drain();

    // Reset in the middle of a backpressured packet
    lat_mode = 1'b0;
    out_ready = 1'b0;
    send(mk(1'b1, 1'b0, 8'd0, 8'h60, 1'b1, 2'd0, 1'b0));
    send(mk(1'b0, 1'b0, 8'd0, 8'h61, 1'b1, 2'd0, 1'b0));
    chk("mid_in_ready_full", in_ready, 0);
    chk("mid_out_data", out_data, 8'h60);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    sb.delete();
    chk("mrst_in_ready", in_ready, 0);
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_out_fields", {out_data, out_channel, out_startofpacket, out_endofpacket}, 0);
    chk("mrst_drop_count", drop_count, 0);
    chk("mrst_orphan", orphan_err, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("mrst_in_ready_back", in_ready, 1);
    lat_mode = 1'b1;
    send(mk(1'b0, 1'b0, 8'd0, 8'h62, 1'b0, 2'd0, 1'b1));
    chk("post_rst_orphan", orphan_err, 1);
    chk("post_rst_drop_count", drop_count, 0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("post_rst_no_output", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
